// File: rtl/encoder_motion_sequencer.sv
// Quadrature encoder decoder with homing / move-to-target motor sequencer.
// Avalon-MM slave: software writes commands, polls status; motor_en/motor_dir drive the PWM block.
module encoder_motion_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1000,
   parameter logic [31:0] ID_VALUE      = 32'hEA680004
) (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [31:0] avs_ctrl_writedata,
   output logic [31:0] avs_ctrl_readdata,
   input  logic [3:0]  avs_ctrl_byteenable,
   input  logic [2:0]  avs_ctrl_address,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   output logic        avs_ctrl_waitrequest,
   input  logic        A,
   input  logic        B,
   input  logic        Z,
   output logic        motor_en,
   output logic        motor_dir
);

   localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEEK   = 3'd1,
      ST_MOVE   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_a_sync;
   logic [1:0]          r_b_sync;
   logic [1:0]          r_z_sync;
   logic [15:0]         r_position;
   logic [15:0]         r_target;
   logic [31:0]         r_timeout_limit;
   logic [31:0]         r_wd_cnt;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic                r_direction;
   logic                r_error;
   logic                r_motor_en;
   logic                r_motor_dir;
   logic [31:0]         r_readdata;

   logic w_a_rise;
   logic w_busy;
   logic w_wr_ctrl;
   logic w_abort;
   logic w_start_home;
   logic w_start_move;
   logic w_pos_wr;
   logic w_timeout;
   logic w_settle_last;
   logic w_tgt_ahead;
   logic w_motor_en_nxt;
   logic w_motor_dir_nxt;
   logic w_error_nxt;
   logic w_seq_start;
   logic w_z_zero;
   logic w_unused_read;

   assign w_unused_read        = avs_ctrl_read;
   assign avs_ctrl_waitrequest = 1'b0;
   assign avs_ctrl_readdata    = r_readdata;
   assign motor_en             = r_motor_en;
   assign motor_dir            = r_motor_dir;

   assign w_a_rise      = r_a_sync[1] & ~r_a_sync[2];
   assign w_busy        = (r_state == ST_SEEK) || (r_state == ST_MOVE) || (r_state == ST_SETTLE);
   assign w_wr_ctrl     = avs_ctrl_write && (avs_ctrl_address == 3'd1) && avs_ctrl_byteenable[0];
   assign w_abort       = w_wr_ctrl & avs_ctrl_writedata[2];
   assign w_start_home  = w_wr_ctrl & avs_ctrl_writedata[0];
   assign w_start_move  = w_wr_ctrl & avs_ctrl_writedata[1];
   assign w_pos_wr      = avs_ctrl_write && (avs_ctrl_address == 3'd3) && !w_busy;
   assign w_timeout     = ((r_state == ST_SEEK) || (r_state == ST_MOVE)) &&
                          (r_timeout_limit != 32'd0) &&
                          (r_wd_cnt == (r_timeout_limit - 32'd1));
   assign w_settle_last = (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
   assign w_tgt_ahead   = $signed(r_target) > $signed(r_position);

   // Two-flop synchronizers; third A flop provides the edge-detect history
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_a_sync <= 3'd0;
         r_b_sync <= 2'd0;
         r_z_sync <= 2'd0;
      end else begin
         r_a_sync <= {r_a_sync[1:0], A};
         r_b_sync <= {r_b_sync[0], B};
         r_z_sync <= {r_z_sync[0], Z};
      end
   end

   // Position counter: bus write (when idle) beats homing zero beats encoder edge
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_position  <= 16'd0;
         r_direction <= 1'b0;
      end else begin
         if (w_pos_wr) begin
            r_position <= avs_ctrl_writedata[15:0];
         end else if (w_z_zero) begin
            r_position <= 16'd0;
         end else if (w_a_rise) begin
            r_position <= r_b_sync[1] ? (r_position + 16'd1) : (r_position - 16'd1);
         end
         if (w_a_rise) begin
            r_direction <= r_b_sync[1];
         end
      end
   end

   // Software-writable target and watchdog limit
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_target        <= 16'd0;
         r_timeout_limit <= 32'd0;
      end else if (avs_ctrl_write) begin
         if (avs_ctrl_address == 3'd2) begin
            if (avs_ctrl_byteenable[0]) r_target[7:0]  <= avs_ctrl_writedata[7:0];
            if (avs_ctrl_byteenable[1]) r_target[15:8] <= avs_ctrl_writedata[15:8];
         end
         if (avs_ctrl_address == 3'd4) begin
            for (int i = 0; i < 4; i++) begin
               if (avs_ctrl_byteenable[i]) r_timeout_limit[i*8 +: 8] <= avs_ctrl_writedata[i*8 +: 8];
            end
         end
      end
   end

   // Watchdog and settle counters
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_wd_cnt     <= 32'd0;
         r_settle_cnt <= '0;
      end else begin
         if (w_seq_start || !((r_state == ST_SEEK) || (r_state == ST_MOVE))) begin
            r_wd_cnt <= 32'd0;
         end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
         end
         if ((r_state == ST_SETTLE) && !w_settle_last) begin
            r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
         end else begin
            r_settle_cnt <= '0;
         end
      end
   end

   // FSM state, error flag and registered motor outputs
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_state     <= ST_IDLE;
         r_error     <= 1'b0;
         r_motor_en  <= 1'b0;
         r_motor_dir <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_error     <= w_error_nxt;
         r_motor_en  <= w_motor_en_nxt;
         r_motor_dir <= w_motor_dir_nxt;
      end
   end

   // Next-state and next-output logic: abort first, then timeout, then per-state progress
   always_comb begin
      w_state_nxt     = r_state;
      w_motor_en_nxt  = 1'b0;
      w_motor_dir_nxt = r_motor_dir;
      w_error_nxt     = r_error;
      w_seq_start     = 1'b0;
      w_z_zero        = 1'b0;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
         w_error_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (w_start_home) begin
                  w_seq_start     = 1'b1;
                  w_error_nxt     = 1'b0;
                  w_state_nxt     = ST_SEEK;
                  w_motor_en_nxt  = 1'b1;
                  w_motor_dir_nxt = avs_ctrl_writedata[3];
               end else if (w_start_move) begin
                  w_seq_start = 1'b1;
                  w_error_nxt = 1'b0;
                  if (r_target == r_position) begin
                     w_state_nxt = ST_SETTLE;
                  end else begin
                     w_state_nxt     = ST_MOVE;
                     w_motor_en_nxt  = 1'b1;
                     w_motor_dir_nxt = w_tgt_ahead;
                  end
               end
            end
            ST_SEEK: begin
               if (w_timeout) begin
                  w_state_nxt = ST_ERROR;
                  w_error_nxt = 1'b1;
               end else if (r_z_sync[1]) begin
                  w_state_nxt = ST_SETTLE;
                  w_z_zero    = 1'b1;
               end else begin
                  w_motor_en_nxt = 1'b1;
               end
            end
            ST_MOVE: begin
               if (w_timeout) begin
                  w_state_nxt = ST_ERROR;
                  w_error_nxt = 1'b1;
               end else if (r_position == r_target) begin
                  w_state_nxt = ST_SETTLE;
               end else begin
                  w_motor_en_nxt  = 1'b1;
                  w_motor_dir_nxt = w_tgt_ahead;
               end
            end
            ST_SETTLE: begin
               if (w_settle_last) begin
                  w_state_nxt = ST_DONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Registered read mux, refreshed every clock
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         r_readdata <= 32'd0;
      end else begin
         case (avs_ctrl_address)
            3'd0:    r_readdata <= ID_VALUE;
            3'd1:    r_readdata <= {24'd0, r_direction, r_error, w_busy, 2'b00, r_state};
            3'd2:    r_readdata <= {16'd0, r_target};
            3'd3:    r_readdata <= {16'd0, r_position};
            3'd4:    r_readdata <= r_timeout_limit;
            default: r_readdata <= 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_motion_sequencer.sv
// Directed bench for encoder_motion_sequencer: register vector table plus motion sequences.
module tb_encoder_motion_sequencer;

   localparam int unsigned SC = 20;
   localparam logic [31:0] ID = 32'hEA680004;

   logic        clk;
   logic        rst;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  be;
   logic [2:0]  addr;
   logic        wr;
   logic        rd;
   logic        waitreq;
   logic        enc_a;
   logic        enc_b;
   logic        enc_z;
   logic        m_en;
   logic        m_dir;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[15];

   encoder_motion_sequencer #(.SETTLE_CYCLES(SC), .ID_VALUE(ID)) dut (
      .csi_MCLK_clk         (clk),
      .rsi_MRST_reset       (rst),
      .avs_ctrl_writedata   (wdata),
      .avs_ctrl_readdata    (rdata),
      .avs_ctrl_byteenable  (be),
      .avs_ctrl_address     (addr),
      .avs_ctrl_write       (wr),
      .avs_ctrl_read        (rd),
      .avs_ctrl_waitrequest (waitreq),
      .A                    (enc_a),
      .B                    (enc_b),
      .Z                    (enc_z),
      .motor_en             (m_en),
      .motor_dir            (m_dir)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // All tasks are entered and left on a falling clock edge
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
      addr  = a;
      wdata = d;
      be    = b;
      wr    = 1'b1;
      @(negedge clk);
      wr    = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      addr = a;
      rd   = 1'b1;
      @(negedge clk);
      d    = rdata;
      rd   = 1'b0;
   endtask

   task automatic pulse(input logic bval);
      enc_b = bval;
      @(negedge clk);
      enc_a = 1'b1;
      repeat (4) @(negedge clk);
      enc_a = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, output int k);
      addr = 3'd1;
      k    = budget + 1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (rdata[2:0] == st) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      int k;
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      wdata  = 32'd0;
      be     = 4'h0;
      addr   = 3'd0;
      wr     = 1'b0;
      rd     = 1'b0;
      enc_a  = 1'b0;
      enc_b  = 1'b0;
      enc_z  = 1'b0;

      vecs[0]  = '{3'd2, 32'h1234ABCD, 4'hF,    32'h0000ABCD};
      vecs[1]  = '{3'd2, 32'h00005678, 4'b0001, 32'h0000AB78};
      vecs[2]  = '{3'd2, 32'h00009900, 4'b0010, 32'h00009978};
      vecs[3]  = '{3'd2, 32'hFFFF0000, 4'b1100, 32'h00009978};
      vecs[4]  = '{3'd4, 32'h12345678, 4'hF,    32'h12345678};
      vecs[5]  = '{3'd4, 32'hAABBCCDD, 4'b0100, 32'h12BB5678};
      vecs[6]  = '{3'd4, 32'hAABBCCDD, 4'b1001, 32'hAABB56DD};
      vecs[7]  = '{3'd4, 32'h00000000, 4'hF,    32'h00000000};
      vecs[8]  = '{3'd5, 32'hFFFFFFFF, 4'hF,    32'h00000000};
      vecs[9]  = '{3'd6, 32'hFFFFFFFF, 4'hF,    32'h00000000};
      vecs[10] = '{3'd7, 32'hFFFFFFFF, 4'hF,    32'h00000000};
      vecs[11] = '{3'd0, 32'h00000000, 4'hF,    ID};
      vecs[12] = '{3'd3, 32'h0000BEEF, 4'hF,    32'h0000BEEF};
      vecs[13] = '{3'd3, 32'h00000000, 4'hF,    32'h00000000};
      vecs[14] = '{3'd2, 32'h00000000, 4'b0011, 32'h00000000};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_readdata", rdata, 32'd0);
      check("rst_motor_en", {31'd0, m_en}, 32'd0);
      check("rst_motor_dir", {31'd0, m_dir}, 32'd0);
      check("waitrequest", {31'd0, waitreq}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      bus_read(3'd0, d);
      check("id_read", d, ID);
      bus_read(3'd1, d);
      check("ctrl_after_rst", d, 32'd0);
      bus_read(3'd3, d);
      check("pos_after_rst", d, 32'd0);

      // Register vector table
      for (int i = 0; i < 15; i++) begin
         bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
         bus_read(vecs[i].addr, d);
         check($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      // Quadrature decode
      for (int i = 0; i < 5; i++) pulse(1'b1);
      bus_read(3'd3, d);
      check("pos_up5", d, 32'd5);
      bus_read(3'd1, d);
      check("dir_up", d, 32'h80);
      for (int i = 0; i < 2; i++) pulse(1'b0);
      bus_read(3'd3, d);
      check("pos_3", d, 32'd3);
      bus_read(3'd1, d);
      check("dir_down", d, 32'h00);
      bus_write(3'd3, 32'd0, 4'hF);
      pulse(1'b0);
      bus_read(3'd3, d);
      check("pos_wrap", d, 32'h0000FFFF);

      // Homing with Z after ~50 clocks
      bus_write(3'd3, 32'd100, 4'hF);
      bus_write(3'd1, 32'h1, 4'hF);
      check("seek_en", {31'd0, m_en}, 32'd1);
      check("seek_dir", {31'd0, m_dir}, 32'd0);
      bus_read(3'd1, d);
      check("seek_status", d, 32'h21);
      bus_read(3'd3, d);
      check("seek_pos", d, 32'd100);
      repeat (48) @(negedge clk);
      check("seek_en_50", {31'd0, m_en}, 32'd1);
      enc_z = 1'b1;
      repeat (2) @(negedge clk);
      check("seek_en_prez", {31'd0, m_en}, 32'd1);
      @(negedge clk);
      check("z_motor_off", {31'd0, m_en}, 32'd0);
      enc_z = 1'b0;
      wait_state(3'd4, 3 * SC, k);
      check("home_settle_len", k, SC + 1);
      bus_read(3'd1, d);
      check("home_done", d, 32'h04);
      bus_read(3'd3, d);
      check("home_pos0", d, 32'd0);
      check("home_en_off", {31'd0, m_en}, 32'd0);

      // Move to -4
      bus_write(3'd2, 32'h0000FFFC, 4'b0011);
      bus_write(3'd1, 32'h2, 4'hF);
      check("move_en", {31'd0, m_en}, 32'd1);
      check("move_dir", {31'd0, m_dir}, 32'd0);
      for (int i = 0; i < 3; i++) pulse(1'b0);
      check("move_en_mid", {31'd0, m_en}, 32'd1);
      pulse(1'b0);
      check("move_en_off", {31'd0, m_en}, 32'd0);
      bus_read(3'd1, d);
      check("move_settle", d, 32'h23);
      wait_state(3'd4, 3 * SC, k);
      bus_read(3'd1, d);
      check("move_done", d, 32'h04);
      bus_read(3'd3, d);
      check("move_pos", d, 32'h0000FFFC);

      // Watchdog timeout during homing with no Z
      bus_write(3'd4, 32'd200, 4'hF);
      bus_write(3'd1, 32'h9, 4'hF);
      check("to_dir", {31'd0, m_dir}, 32'd1);
      k = 401;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (!m_en) begin
            k = i;
            break;
         end
      end
      check("timeout_clk", k, 200);
      bus_read(3'd1, d);
      check("timeout_err", d, 32'h45);
      bus_write(3'd1, 32'h2, 4'hF);
      bus_read(3'd1, d);
      check("err_cleared", d, 32'h23);
      wait_state(3'd4, 3 * SC, k);
      bus_read(3'd1, d);
      check("eq_move_done", d, 32'h04);

      // Commands and writes while moving
      bus_write(3'd4, 32'd0, 4'hF);
      bus_write(3'd2, 32'h0000000A, 4'b0011);
      bus_write(3'd1, 32'h2, 4'hF);
      check("mv2_en", {31'd0, m_en}, 32'd1);
      check("mv2_dir", {31'd0, m_dir}, 32'd1);
      bus_write(3'd1, 32'h1, 4'hF);
      bus_read(3'd1, d);
      check("home_ignored", d, 32'h22);
      bus_write(3'd3, 32'h1234, 4'hF);
      bus_read(3'd3, d);
      check("poswr_ignored", d, 32'h0000FFFC);
      bus_write(3'd1, 32'h6, 4'hF);
      check("abort_start_en", {31'd0, m_en}, 32'd0);
      bus_read(3'd1, d);
      check("abort_start_idle", d, 32'h00);
      bus_write(3'd1, 32'h2, 4'hF);
      check("mv3_en", {31'd0, m_en}, 32'd1);
      bus_write(3'd1, 32'h4, 4'hF);
      check("abort_en", {31'd0, m_en}, 32'd0);
      bus_read(3'd1, d);
      check("abort_idle", d, 32'h00);

      // Asynchronous reset in the middle of a move
      bus_write(3'd1, 32'h2, 4'hF);
      check("mv4_en", {31'd0, m_en}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_en", {31'd0, m_en}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_read(3'd1, d);
      check("arst_state", d, 32'h00);
      bus_read(3'd2, d);
      check("arst_target", d, 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
